// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed N-digit seven-segment scan driver
// Scans one digit per slot, blanks the last cycle of each slot to avoid ghosting.
module seg_scan_driver #(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*N_DIGITS-1:0]   digits,
   input  logic [N_DIGITS-1:0]     blank,
   input  logic                    blink_en,
   output logic [6:0]              seg,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_tick
);

   localparam int CNT_W  = $clog2(SCAN_DIV);
   localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                ph_q, ph_d;
   logic [6:0]          seg_q, seg_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic                tick_q, tick_d;

   logic                slot_end, last_digit, frame_end;
   logic [3:0]          cur_nib;
   logic                cur_blank;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h40;
         4'h1: hex7 = 7'h79;
         4'h2: hex7 = 7'h24;
         4'h3: hex7 = 7'h30;
         4'h4: hex7 = 7'h19;
         4'h5: hex7 = 7'h12;
         4'h6: hex7 = 7'h02;
         4'h7: hex7 = 7'h78;
         4'h8: hex7 = 7'h00;
         4'h9: hex7 = 7'h10;
         4'hA: hex7 = 7'h08;
         4'hB: hex7 = 7'h03;
         4'hC: hex7 = 7'h46;
         4'hD: hex7 = 7'h21;
         4'hE: hex7 = 7'h06;
         default: hex7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      slot_end   = (cnt_q == CNT_W'(SCAN_DIV - 1));
      last_digit = (idx_q == IDX_W'(N_DIGITS - 1));
      frame_end  = slot_end && last_digit;

      // Explicit mux avoids a variable part-select whose index math overflows idx width.
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib   = digits[4*i +: 4];
            cur_blank = blank[i];
         end
      end

      cnt_d = slot_end ? '0 : cnt_q + 1'b1;

      idx_d = idx_q;
      if (slot_end)
         idx_d = last_digit ? '0 : idx_q + 1'b1;

      fcnt_d = fcnt_q;
      ph_d   = ph_q;
      if (frame_end) begin
         if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
            fcnt_d = '0;
            ph_d   = ~ph_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end

      an_d  = '1;
      seg_d = 7'h7F;
      if (!slot_end && !cur_blank && !(blink_en && ph_q)) begin
         an_d  = ~(N_DIGITS'(1) << idx_q);
         seg_d = hex7(cur_nib);
      end

      tick_d = frame_end;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         fcnt_q <= '0;
         ph_q   <= 1'b0;
         seg_q  <= 7'h7F;
         an_q   <= '1;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         fcnt_q <= fcnt_d;
         ph_q   <= ph_d;
         seg_q  <= seg_d;
         an_q   <= an_d;
         tick_q <= tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver
// A behavioural model predicts each edge's outputs into a queue; observed outputs are popped and compared.
module tb_seg_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int BF = 2;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [4*ND-1:0] digits = '0;
   logic [ND-1:0]   blank = '0;
   logic            blink_en = 1'b0;
   logic [6:0]      seg;
   logic [ND-1:0]   an;
   logic            frame_tick;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int m_cnt, m_idx, m_fcnt, m_ph;
   logic [11:0] exp_q [$];
   logic [ND-1:0] obs_an;
   logic [6:0]    obs_seg;
   logic          obs_tick;

   seg_scan_driver #(.N_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .reset(reset), .digits(digits), .blank(blank), .blink_en(blink_en),
      .seg(seg), .an(an), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = 0; m_fcnt = 0; m_ph = 0;
   endtask

   task automatic step();
      logic [ND-1:0] e_an;
      logic [6:0]    e_seg;
      logic          e_tick, se;
      logic [11:0]   e;
      logic [3:0]    nib;
      se     = (m_cnt == SD - 1);
      e_tick = se && (m_idx == ND - 1);
      nib    = digits[4*m_idx +: 4];
      if (se || blank[m_idx] || (blink_en && m_ph != 0)) begin
         e_an = '1; e_seg = 7'h7F;
      end else begin
         e_an = '1; e_an[m_idx] = 1'b0; e_seg = hex_tab[nib];
      end
      exp_q.push_back({e_tick, e_an, e_seg});
      if (e_tick) begin
         if (m_fcnt == BF - 1) begin m_fcnt = 0; m_ph = 1 - m_ph; end
         else m_fcnt++;
      end
      if (se) m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
      m_cnt = se ? 0 : m_cnt + 1;

      @(posedge clk);
      #1;
      obs_an = an; obs_seg = seg; obs_tick = frame_tick;
      if (exp_q.size() == 0) begin
         chk("queue_underflow", 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk("an", obs_an, e[10:7]);
         chk("seg", obs_seg, e[6:0]);
         chk("frame_tick", obs_tick, e[11]);
      end
      chk("an_onehot", ($countones(~obs_an) <= 1), 1);
      chk("dark_seg", (obs_an != '1) || (obs_seg == 7'h7F), 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_tick", frame_tick, 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int ticks, first_tick, second_tick, cnt2;
      int lit [8];

      // basic scan order and guard
      digits = 16'h3210;
      do_reset();
      step();
      chk("d0_an", obs_an, 4'b1110);
      chk("d0_seg", obs_seg, 7'h40);
      step(); step(); step();
      chk("guard_an", obs_an, 4'b1111);
      chk("guard_seg", obs_seg, 7'h7F);
      step();
      chk("d1_an", obs_an, 4'b1101);
      chk("d1_seg", obs_seg, 7'h79);
      for (int k = 0; k < 15; k++) step();

      // frame tick single pulse, 16-cycle period
      digits = 16'hFEDC;
      do_reset();
      ticks = 0; first_tick = -1; second_tick = -1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (k == 0) chk("c_seg", obs_seg, 7'h46);
         if (obs_tick) begin
            ticks++;
            if (first_tick < 0) first_tick = k;
            else if (second_tick < 0) second_tick = k;
         end
      end
      chk("tick_count", ticks, 2);
      chk("tick_first", first_tick, 15);
      chk("tick_period", second_tick - first_tick, 16);

      // per-digit blank
      digits = 16'h8888; blank = 4'b0100;
      do_reset();
      cnt2 = 0;
      for (int k = 0; k < 32; k++) begin
         step();
         if (obs_an == 4'b1011) cnt2++;
      end
      chk("blank_d2", cnt2, 0);
      blank = '0;

      // blink: two frames lit, two dark
      digits = 16'h3210; blink_en = 1'b1;
      do_reset();
      for (int f = 0; f < 8; f++) lit[f] = 0;
      for (int k = 0; k < 96; k++) begin
         step();
         if (obs_an != 4'hF) lit[k/16]++;
      end
      chk("blink_f0", lit[0], 12);
      chk("blink_f1", lit[1], 12);
      chk("blink_f2", lit[2], 0);
      chk("blink_f3", lit[3], 0);
      chk("blink_f4", lit[4], 12);
      chk("blink_f5", lit[5], 12);
      step(); step();
      chk("blink_dark", obs_an, 4'hF);
      blink_en = 1'b0;
      step();
      chk("blink_release", obs_an, 4'b1110);
      for (int k = 0; k < 8; k++) step();

      // asynchronous reset in digit 2 slot
      do_reset();
      for (int k = 0; k < 10; k++) step();
      chk("pre_rst_an", obs_an, 4'b1011);
      #2;
      reset = 1'b1;
      #1;
      chk("async_an", an, 4'hF);
      chk("async_seg", seg, 7'h7F);
      do_reset();
      step();
      chk("restart_an", obs_an, 4'b1110);
      for (int k = 0; k < 6; k++) step();

      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. Next generation of the single-digit state decoder.
- Takes packed hex nibbles, a per-digit blank mask and a blink enable. Scans one digit at a time with a one-cycle anti-ghosting guard.
- Sits between the lock FSM / password datapath and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits scanned; legal 1..8.
- SCAN_DIV, 1000, clock cycles per digit slot including the guard cycle; legal >= 2.
- BLINK_FRAMES, 64, full scan frames per blink half-period; legal >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- digits  in  4*N_DIGITS  hex code per digit; digit i = digits[4i+3:4i]; digit 0 drives an[0]
- blank  in  N_DIGITS  1 = digit i shows no segments
- blink_en  in  1  1 = whole display blinks (alarm indication)
- seg  out  7  segment drive, active-low, bit6..bit0 = g,f,e,d,c,b,a
- an  out  N_DIGITS  digit enables, active-low, at most one low at any time
- frame_tick  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (async, immediate):
  - prescaler cnt=0, digit index idx=0, frame counter fcnt=0, blink phase ph=0
  - an = all ones, seg = 7'h7F, frame_tick = 0
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - slot_end = (cnt == SCAN_DIV-1).
- Index:
  - On slot_end, idx <= (idx == N_DIGITS-1) ? 0 : idx+1.
  - N_DIGITS=1: idx stays 0.
- Outputs are registered and updated every clock edge.
- Guard (edge where slot_end is true): an <= all ones, seg <= 7'h7F.
- Drive (all other edges):
  - If blank[idx], or blink_en && ph: an <= all ones, seg <= 7'h7F.
  - Otherwise an <= one-hot-low at idx, seg <= hex(digits[idx]).
- Each digit is lit for SCAN_DIV-1 cycles, then 1 guard cycle.
- Input latency is 1 cycle. digits, blank and blink_en are sampled live, with no latching per slot.
- Hex table (active-low, hex values of seg):
  - 0:40  1:79  2:24  3:30  4:19  5:12  6:02  7:78
  - 8:00  9:10  A:08  b:03  C:46  d:21  E:06  F:0E
- Frame:
  - frame_end = slot_end && idx == N_DIGITS-1.
  - frame_tick <= frame_end, registered, high exactly one cycle.
- Blink:
  - On frame_end, if fcnt == BLINK_FRAMES-1 then fcnt <= 0 and ph <= ~ph; else fcnt <= fcnt+1.
  - The blink counter runs regardless of blink_en.
  - Deasserting blink_en restores the display on the next edge.
- Reset mid-scan: all state returns to reset values; scanning restarts at digit 0 with the first digit lit at cycle 1 after release.
- Invariant: an never has more than one zero bit. seg is 7'h7F whenever an is all ones.

Test Plan:
- Bench parameters: N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset then release, digits=16'h3210, blank=0 -> first edge an=4'b1110, seg=7'h40 for 3 cycles; guard an=4'b1111, seg=7'h7F; then an=4'b1101, seg=7'h79, then digits 2 and 3 (seg 24, 30); wraps to an=1110.
- digits=16'hFEDC, run one frame -> seg sequence 46,21,06,0E on an 1110,1101,1011,0111; frame_tick single pulse after digit 3 guard, period 16 cycles.
- blank=4'b0100, digits=16'h8888 -> digit 2 slot shows an=1111, seg=7F; other slots seg=00.
- blink_en=1 from reset -> display lit for frames 0-1, dark (an=1111) for frames 2-3, lit for frames 4-5; deassert blink_en during a dark frame -> next edge lit again.
- Assert reset during digit 2 slot -> an=1111, seg=7F asynchronously; after release scan restarts at an=1110.
- Checker over all scenarios: an has at most one zero each cycle, and seg==7F whenever an==all ones.
